// File: rtl/laser_pkg.sv
// Shared constants and types for the LASER point sequencer front end.
package laser_pkg;

    localparam int unsigned NPTS = 40;
    localparam int unsigned CW   = 4;
    localparam int unsigned IDXW = $clog2(NPTS + 1);

    typedef enum logic [1:0] {
        FILL,
        STREAM,
        RUN,
        RESULT
    } state_t;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } pt_t;

    typedef struct packed {
        logic [CW-1:0] c1x;
        logic [CW-1:0] c1y;
        logic [CW-1:0] c2x;
        logic [CW-1:0] c2y;
        logic          err;
    } laser_res_t;

endpackage

// File: rtl/laser_pt_buf.sv
// Point-set storage: one write port, one combinational read port.
module laser_pt_buf
    import laser_pkg::*;
(
    input  logic            CLK,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  pt_t             wr_pt,
    input  logic [IDXW-1:0] rd_idx,
    output pt_t             rd_pt
);

    pt_t mem [NPTS];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_pt;
        end
    end

    assign rd_pt = mem[rd_idx];

endmodule

// File: rtl/laser_point_sequencer.sv
// Buffers a 40-point set, streams it gap-free into LASER, then returns the
// captured circle centres (or a watchdog timeout) on a valid/ready port.
module laser_point_sequencer
    import laser_pkg::*;
#(
    parameter int unsigned MAX_RUN = 8191
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_x,
    input  logic [CW-1:0] in_y,
    output logic          laser_rst,
    output logic [CW-1:0] laser_x,
    output logic [CW-1:0] laser_y,
    input  logic          laser_done,
    input  logic [CW-1:0] laser_c1x,
    input  logic [CW-1:0] laser_c1y,
    input  logic [CW-1:0] laser_c2x,
    input  logic [CW-1:0] laser_c2y,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] res_c1x,
    output logic [CW-1:0] res_c1y,
    output logic [CW-1:0] res_c2x,
    output logic [CW-1:0] res_c2y,
    output logic          res_err,
    output logic          busy
);

    localparam int unsigned     WDW      = $clog2(MAX_RUN + 1);
    localparam logic [IDXW-1:0] FULL     = IDXW'(NPTS);
    localparam logic [IDXW-1:0] LAST     = IDXW'(NPTS - 1);
    localparam logic [WDW-1:0]  WD_LIMIT = WDW'(MAX_RUN);

    state_t          state, state_nxt;
    logic [IDXW-1:0] fill_cnt;
    logic [IDXW-1:0] rd_idx, rd_idx_nxt;
    logic [WDW-1:0]  watchdog;
    logic            accept;
    pt_t             in_pt, rd_pt;
    laser_res_t      res_q;

    assign in_ready = (state != STREAM) && (fill_cnt < FULL);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != FILL) || (fill_cnt != '0);
    assign in_pt    = '{x: in_x, y: in_y};

    assign {res_c1x, res_c1y, res_c2x, res_c2y, res_err} = res_q;

    laser_pt_buf u_buf (
        .CLK    (CLK),
        .wr_en  (accept),
        .wr_idx (fill_cnt),
        .wr_pt  (in_pt),
        .rd_idx (rd_idx_nxt),
        .rd_pt  (rd_pt)
    );

    always_comb begin
        state_nxt  = state;
        rd_idx_nxt = '0;
        unique case (state)
            FILL:   if (fill_cnt == FULL) state_nxt = STREAM;
            STREAM: begin
                if (rd_idx == LAST) state_nxt = RUN;
                else                rd_idx_nxt = rd_idx + 1'b1;
            end
            RUN:    if (laser_done || (watchdog == WD_LIMIT)) state_nxt = RESULT;
            RESULT: if (res_ready) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // LASER-facing registers are loaded from the next state so laser_rst
    // drops on the very cycle point 0 first appears on laser_x/y.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= FILL;
            fill_cnt  <= '0;
            rd_idx    <= '0;
            watchdog  <= '0;
            laser_rst <= 1'b1;
            laser_x   <= '0;
            laser_y   <= '0;
            res_valid <= 1'b0;
            res_q     <= '0;
        end else begin
            state     <= state_nxt;
            rd_idx    <= rd_idx_nxt;
            laser_rst <= (state_nxt == FILL) || (state_nxt == RESULT);
            res_valid <= (state_nxt == RESULT);

            if (state_nxt == STREAM) begin
                laser_x <= rd_pt.x;
                laser_y <= rd_pt.y;
            end else begin
                laser_x <= '0;
                laser_y <= '0;
            end

            if ((state == STREAM) && (rd_idx == LAST)) fill_cnt <= '0;
            else if (accept)                           fill_cnt <= fill_cnt + 1'b1;

            if ((state == RUN) && (state_nxt == RUN)) watchdog <= watchdog + 1'b1;
            else                                       watchdog <= '0;

            if (state == RUN) begin
                if (laser_done) begin
                    res_q <= '{c1x: laser_c1x, c1y: laser_c1y,
                               c2x: laser_c2x, c2y: laser_c2y, err: 1'b0};
                end else if (watchdog == WD_LIMIT) begin
                    res_q <= '{c1x: '0, c1y: '0, c2x: '0, c2y: '0, err: 1'b1};
                end
            end
        end
    end

endmodule

// File: doc/laser_point_sequencer.md
Name: laser_point_sequencer

Overview:
- Front-end stage for the LASER two-circle coverage engine.
- Buffers one 40-point set arriving over a valid/ready stream.
- Holds LASER in reset until a full set is buffered, then streams the set on 40 consecutive cycles, which LASER's INPUT phase requires.
- Waits for DONE, captures C1/C2, and returns them on a valid/ready result port. Includes a watchdog on the LASER run.

Parameters:
- NPTS, 40, points per set (LASER fixed at 40).
- CW, 4, coordinate width.
- MAX_RUN, 8191, max cycles from stream end to DONE before timeout; counter width is $clog2(MAX_RUN+1).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- in_valid  in  1  point valid
- in_ready  out  1  point accepted when in_valid&&in_ready
- in_x  in  CW  point X
- in_y  in  CW  point Y
- laser_rst  out  1  registered reset to LASER, high = hold LASER in INPUT/counter 0
- laser_x  out  CW  to LASER X
- laser_y  out  CW  to LASER Y
- laser_done  in  1  LASER DONE
- laser_c1x, laser_c1y, laser_c2x, laser_c2y  in  CW each  LASER results
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid&&res_ready
- res_c1x, res_c1y, res_c2x, res_c2y  out  CW each  captured circle centres
- res_err  out  1  result is a timeout (centres forced 0)
- busy  out  1  state != FILL or fill_cnt != 0

Behaviour:
- Interface: one clock CLK; RST is synchronous, active-high.
- Reset values:
  - state=FILL, fill_cnt=0, laser_rst=1.
  - laser_x/y=0, res_valid=0, res_* =0, res_err=0, watchdog=0.
- States FILL, STREAM, RUN, RESULT:
  - FILL: wait for fill_cnt==NPTS, then enter STREAM next cycle. laser_rst=1.
  - STREAM: rd_idx 0..NPTS-1, one point per cycle, no gaps.
    - laser_x/y = point[rd_idx]; laser_rst=0 from rd_idx=0 onward, so LASER's first unreset edge captures point 0.
    - At rd_idx==NPTS-1: clear fill_cnt and go to RUN.
  - RUN: laser_rst=0; watchdog counts up each cycle.
    - laser_done sampled 1: capture laser_c*, res_err=0, laser_rst<=1 on the same edge, go to RESULT.
    - watchdog==MAX_RUN without DONE: res_c* =0, res_err=1, laser_rst<=1, go to RESULT.
    - DONE on the same cycle as the limit: DONE wins, res_err=0.
  - RESULT: res_valid=1 with res_* stable until res_ready. On handshake, res_valid<=0 and go to FILL. If the buffer is already full, STREAM starts the following cycle (minimum one-cycle FILL visit).
- Point order: arrival order; point k is written at index k.
- in_ready = (state!=STREAM) && (fill_cnt<NPTS).
  - Filling the next set is allowed during RUN and RESULT; the buffer is free once STREAM ends.
  - in_valid with in_ready=0 is ignored and data is not captured. in_valid gaps are legal.
- fill_cnt saturates at NPTS; 41st and later points are back-pressured, never overwrite.
- laser_x/y are don't-care outside STREAM; drive 0.
- RST mid-operation (any state) returns to reset values. Partially filled points are discarded, laser_rst=1 next cycle, pending result is lost.
- Latency:
  - Last point accepted in FILL -> first STREAM cycle: 1 cycle.
  - laser_done -> res_valid: 1 cycle.
- All outputs are registered except in_ready and busy.

Decomposition:
- Package laser_pkg:
  - Constants: NPTS, CW.
  - State enum: FILL, STREAM, RUN, RESULT.
  - Typedef pt_t {x,y}.
  - Typedef laser_res_t {c1x,c1y,c2x,c2y,err}.
- Sub-module laser_pt_buf: NPTS x 2*CW register array with write port (wr_en, wr_idx) and combinational read (rd_idx).
- FSM, counters and watchdog stay in the top.

Test Plan:
- Basic: push 40 points (0,0),(1,1)...(15,15),(0,1)... with in_valid continuous; LASER model asserts DONE 500 cycles after stream with C1=(3,4), C2=(11,9) -> laser_rst falls exactly with pt0 on laser_x/y; 40 consecutive points in order; res_valid 1 cycle after DONE with (3,4,11,9), res_err=0.
- Back-to-back: push set B during RUN -> in_ready drops after 40 B points. After res handshake, STREAM of B starts 2 cycles later (RESULT->FILL->STREAM).
- Result stall: hold res_ready=0 for 100 cycles -> res_* stable, laser_rst=1 throughout, no new STREAM; release -> single handshake.
- Timeout: LASER model never asserts DONE -> after MAX_RUN cycles res_valid=1, res_err=1, res_c* =0, laser_rst=1.
- Reset mid-STREAM at rd_idx=17 -> next cycle laser_rst=1, fill_cnt=0, res_valid=0. A fresh 40-point set then completes normally.
- Gappy input: in_valid toggling every other cycle plus a 41st point offered -> exactly 40 captured; 41st held until the next fill window.
